i2c_req_arbiter: RTL



---
 rtl/i2c_req_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one i2c master among NUM_REQ requesters and
// sequences each granted transaction through issue, active and completion.
module i2c_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ-1:0]               req_rw,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic [NUM_REQ-1:0]               err,
  output logic                             m_data_rdy,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_rw,
  input  logic                             m_busy,
  output logic                             busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_ACTIVE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          owner_q, owner_d;
  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic [NUM_REQ-1:0]     err_q, err_d;
  logic                   rdy_q, rdy_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   rw_q, rw_d;
  logic                   busy_q, busy_d;

  logic                   found;
  logic [PW-1:0]          pick;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic                   sel_rw;

  // Wait-phase counter holds at TIMEOUT instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    int          idx;
    logic [PW-1:0] idx_b;
    found    = 1'b0;
    pick     = '0;
    idx      = 0;
    idx_b    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx   = (int'(ptr_q) + k) % NUM_REQ;
      idx_b = PW'(idx);
      if (!found && req[idx_b]) begin
        found = 1'b1;
        pick  = idx_b;
      end
    end
    sel_addr = '0;
    sel_data = '0;
    sel_rw   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PW'(i) == pick) begin
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_rw   = req_rw[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = sat_inc(cnt_q);
    ptr_d   = ptr_q;
    owner_d = owner_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    rdy_d   = rdy_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rw_d    = rw_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (en && found) begin
          state_d = S_ISSUE;
          gnt_d   = ONE_HOT0 << pick;
          owner_d = pick;
          addr_d  = sel_addr;
          data_d  = sel_data;
          rw_d    = sel_rw;
          rdy_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        if (m_busy) begin
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = gnt_q;
          rdy_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_ACTIVE: begin
        if (!m_busy) begin
          done_d  = gnt_q;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          err_d   = gnt_q;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Last owner becomes lowest priority for the next round.
        ptr_d   = owner_q;
        gnt_d   = '0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        rdy_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      owner_q <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdy_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rw_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rw_q    <= rw_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign m_data_rdy = rdy_q;
  assign m_addr     = addr_q;
  assign m_data     = data_q;
  assign m_rw       = rw_q;
  assign busy       = busy_q;

endmodule
